ivf_frame_streamer: RTL and testbench
=====================================

// Module: ivf_frame_streamer
// PURPOSE
//  Sequences an IVF container held in byte memory (ROM/readmemh image) into the AV2 decoder input.
//  Parses the 32-byte file header and each 12-byte frame header, then streams payload bytes with
//  valid/ready, marking frame start/end. Sits between the bitstream store and the OBU parser.
// PARAMETERS
//  ADDR_W          16     byte-address width of container memory
//  MAX_FRAME_BYTES 65535  largest legal frame payload; larger is a size error
//  FRAME_IDX_W     8      width of frame index counter
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous active-high reset
//  start          in   1       pulse: begin parsing at address 0 (ignored while busy)
//  mem_size       in   ADDR_W  total valid container bytes; sampled on accepted start
//  mem_rd_en      out  1       memory read request
//  mem_addr       out  ADDR_W  read address
//  mem_rdata      in   8       read data, valid exactly 1 cycle after mem_rd_en
//  out_data       out  8       payload byte
//  out_valid      out  1       out_data valid
//  out_ready      in   1       consumer accepts when out_valid&&out_ready
//  out_sof        out  1       first payload byte of a frame
//  out_eof        out  1       last payload byte of a frame
//  out_frame_idx  out  FRAME_IDX_W  index of frame being emitted (0-based)
//  frame_size     out  32      size field of current frame
//  pic_width      out  16      header bytes 12-13 (LE)
//  pic_height     out  16      header bytes 14-15 (LE)
//  num_frames     out  32      header bytes 24-27 (LE)
//  busy           out  1       high from accepted start until DONE/ERR
//  done           out  1       sticky: all frames emitted; cleared by next start
//  error          out  2       sticky code: 0 none,1 bad signature,2 bad frame size,3 truncated
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, output buffer and in-flight read flushed. Reset mid-stream
//    abandons the frame; no further out_valid until a new start.
//  - FSM: IDLE -start-> FILE_HDR (read bytes 0..31) -> FRM_HDR (12 bytes) -> PAYLOAD (frame_size
//    bytes) -> FRM_HDR | DONE; any check failure -> ERR. DONE/ERR -start-> FILE_HDR.
//  - File header: bytes 0..3 must be 'D','K','I','F' else ERR code 1 (checked once byte 3 returns).
//    Header length field (bytes 6-7) ignored; first frame header always at address 32.
//  - Frame header: size = LE32 of bytes 0..3; bytes 4..11 (pts) read and discarded.
//    size==0 or size>MAX_FRAME_BYTES -> ERR code 2. address+size>mem_size -> ERR code 3.
//  - Truncation: any header read at address>=mem_size -> ERR code 3, no read issued.
//  - Termination: DONE after frame num_frames-1 eof is accepted, or when frame header would start
//    at address==mem_size (clean end), whichever first. num_frames==0 -> run to clean end.
//  - Payload buffering: 2-entry output FIFO; read issued when occupancy+in-flight<2, so sustained
//    1 byte/cycle with out_ready held high. First payload byte valid 2 cycles after PAYLOAD entry.
//  - out_valid/out_data/sof/eof/frame_idx held stable while out_valid&&!out_ready.
//  - sof and eof both high on a 1-byte frame. out_frame_idx increments after eof accepted; wraps.
//  - ERR entered while bytes buffered: buffer flushed, out_valid drops next cycle.
//  - mem_addr never exceeds mem_size-1; mem_rd_en never high in IDLE/DONE/ERR.
//  - Header fields (pic_width/height/num_frames) update as bytes arrive; hold until next start.
// TESTING
//  1 64x64 container, 2 frames of 3392 and 47 bytes, out_ready=1 -> 3439 bytes, 2 sof, 2 eof,
//    idx 0 then 1, pic_width=64, pic_height=64, done=1, error=0; bytes match memory image.
//  2 Same, out_ready random 50% -> identical byte sequence, no drop/duplicate, data stable stalled.
//  3 Byte 0 = 'X' -> error=1 within 5 cycles of start, no out_valid ever, busy=0.
//  4 Frame 1 size field 100 with mem_size truncating after 47 -> frame 0 fully emitted, error=3.
//  5 rst asserted mid frame 0 (byte 1000) -> out_valid=0 next cycle; new start replays from sof.
//  6 One-byte frame -> single beat with sof=eof=1; start pulsed while busy ignored.

Source files
------------

// File: rtl/ivf_frame_streamer.sv
// IVF container streamer: walks an IVF image held in byte memory, parses the
// 32-byte file header and each 12-byte frame header, and streams frame payload
// bytes to the decoder through a 2-entry output buffer with valid/ready.
module ivf_frame_streamer #(
    parameter int ADDR_W          = 16,
    parameter int MAX_FRAME_BYTES = 65535,
    parameter int FRAME_IDX_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      mem_size,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [7:0]             mem_rdata,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [FRAME_IDX_W-1:0] out_frame_idx,
    output logic [31:0]            frame_size,
    output logic [15:0]            pic_width,
    output logic [15:0]            pic_height,
    output logic [31:0]            num_frames,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILE_HDR,
        S_FRM_HDR,
        S_PAYLOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] E_SIG   = 2'd1;
    localparam logic [1:0] E_SIZE  = 2'd2;
    localparam logic [1:0] E_TRUNC = 2'd3;

    // Expected file signature "DKIF", one character per header byte 0..3.
    function automatic logic [7:0] sig_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    sig_byte = 8'h44;
            2'd1:    sig_byte = 8'h4B;
            2'd2:    sig_byte = 8'h49;
            default: sig_byte = 8'h46;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      msize_q, msize_d;
    logic [5:0]             hcnt_q, hcnt_d;       // header bytes requested
    logic [5:0]             rcnt_q, rcnt_d;       // header bytes returned
    logic                   rvld_q;               // a read was issued last cycle
    logic                   sig_ok_q, sig_ok_d;
    logic [31:0]            fsize_q, fsize_d;
    logic [15:0]            picw_q, picw_d;
    logic [15:0]            pich_q, pich_d;
    logic [31:0]            nfr_q, nfr_d;
    logic [1:0]             err_q, err_d;
    logic [FRAME_IDX_W-1:0] fidx_q, fidx_d;
    logic [31:0]            fcnt_q, fcnt_d;       // frames completed this run
    logic [31:0]            iss_left_q, iss_left_d;
    logic [31:0]            emit_left_q, emit_left_d;
    logic                   first_q, first_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             occ_q, occ_d;
    logic [7:0]             fifo_q [2];

    logic                   rd_en;
    logic                   push;
    logic                   pop;
    logic [2:0]             occ_next;
    logic [5:0]             hdr_len;
    logic [32:0]            end_addr;

    assign out_valid     = (occ_q != 2'd0);
    assign out_data      = out_valid ? fifo_q[rd_ptr_q] : 8'd0;
    assign out_sof       = out_valid && first_q;
    assign out_eof       = out_valid && (emit_left_q == 32'd1);
    assign out_frame_idx = fidx_q;
    assign frame_size    = fsize_q;
    assign pic_width     = picw_q;
    assign pic_height    = pich_q;
    assign num_frames    = nfr_q;
    assign busy          = (state_q == S_FILE_HDR) || (state_q == S_FRM_HDR) ||
                           (state_q == S_PAYLOAD);
    assign done          = (state_q == S_DONE);
    assign error         = err_q;
    assign mem_rd_en     = rd_en;
    assign mem_addr      = rd_en ? addr_q : '0;

    // Next-state, header parsing, read issue and output-buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        msize_d     = msize_q;
        hcnt_d      = hcnt_q;
        rcnt_d      = rcnt_q;
        sig_ok_d    = sig_ok_q;
        fsize_d     = fsize_q;
        picw_d      = picw_q;
        pich_d      = pich_q;
        nfr_d       = nfr_q;
        err_d       = err_q;
        fidx_d      = fidx_q;
        fcnt_d      = fcnt_q;
        iss_left_d  = iss_left_q;
        emit_left_d = emit_left_q;
        first_d     = first_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        rd_en       = 1'b0;
        push        = 1'b0;
        pop         = out_valid && out_ready;
        occ_next    = 3'd0;
        hdr_len     = (state_q == S_FILE_HDR) ? 6'd32 : 6'd12;
        end_addr    = 33'(addr_q) + 33'(fsize_q);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_FILE_HDR;
                    addr_d   = '0;
                    msize_d  = mem_size;
                    hcnt_d   = 6'd0;
                    rcnt_d   = 6'd0;
                    sig_ok_d = 1'b1;
                    err_d    = 2'd0;
                    fidx_d   = '0;
                    fcnt_d   = 32'd0;
                end
            end

            S_FILE_HDR, S_FRM_HDR: begin
                // Request header bytes back to back; running out of memory
                // exactly at a frame boundary is the clean end of the file.
                if (hcnt_q < hdr_len) begin
                    if (addr_q < msize_q) begin
                        rd_en  = 1'b1;
                        addr_d = addr_q + 1'b1;
                        hcnt_d = hcnt_q + 6'd1;
                    end else if (state_q == S_FRM_HDR && hcnt_q == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = E_TRUNC;
                    end
                end
                if (rvld_q) begin
                    rcnt_d = rcnt_q + 6'd1;
                    if (state_q == S_FILE_HDR) begin
                        case (rcnt_q)
                            6'd0, 6'd1, 6'd2:
                                sig_ok_d = sig_ok_q && (mem_rdata == sig_byte(rcnt_q[1:0]));
                            6'd3:
                                if (!sig_ok_q || mem_rdata != sig_byte(2'd3)) begin
                                    state_d = S_ERR;
                                    err_d   = E_SIG;
                                end
                            6'd12: picw_d[7:0]  = mem_rdata;
                            6'd13: picw_d[15:8] = mem_rdata;
                            6'd14: pich_d[7:0]  = mem_rdata;
                            6'd15: pich_d[15:8] = mem_rdata;
                            6'd24, 6'd25, 6'd26, 6'd27:
                                nfr_d[{rcnt_q[1:0], 3'b000} +: 8] = mem_rdata;
                            6'd31: begin
                                state_d = S_FRM_HDR;
                                hcnt_d  = 6'd0;
                                rcnt_d  = 6'd0;
                            end
                            default: ;
                        endcase
                    end else begin
                        if (rcnt_q < 6'd4) begin
                            fsize_d[{rcnt_q[1:0], 3'b000} +: 8] = mem_rdata;
                        end
                        // Last pts byte: all of the size field is in fsize_q
                        // and addr_q already points at the first payload byte.
                        if (rcnt_q == 6'd11) begin
                            if (fsize_q == 32'd0 || fsize_q > 32'(MAX_FRAME_BYTES)) begin
                                state_d = S_ERR;
                                err_d   = E_SIZE;
                            end else if (end_addr > 33'(msize_q)) begin
                                state_d = S_ERR;
                                err_d   = E_TRUNC;
                            end else begin
                                state_d     = S_PAYLOAD;
                                iss_left_d  = fsize_q;
                                emit_left_d = fsize_q;
                                first_d     = 1'b1;
                            end
                        end
                    end
                end
            end

            S_PAYLOAD: begin
                // Occupancy is judged after this cycle's push and pop so that
                // a steady ready consumer sees one byte every cycle.
                push     = rvld_q;
                occ_next = 3'(occ_q) + 3'(push) - 3'(pop);
                occ_d    = occ_next[1:0];
                if (push) wr_ptr_d = ~wr_ptr_q;
                if (pop)  rd_ptr_d = ~rd_ptr_q;
                if (iss_left_q != 32'd0 && occ_next < 3'd2) begin
                    rd_en      = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    iss_left_d = iss_left_q - 32'd1;
                end
                if (pop) begin
                    first_d     = 1'b0;
                    emit_left_d = emit_left_q - 32'd1;
                    if (emit_left_q == 32'd1) begin
                        fidx_d = fidx_q + 1'b1;
                        fcnt_d = fcnt_q + 32'd1;
                        if (nfr_q != 32'd0 && fcnt_q + 32'd1 == nfr_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FRM_HDR;
                            hcnt_d  = 6'd0;
                            rcnt_d  = 6'd0;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Entering ERR discards anything still buffered.
        if (state_d == S_ERR) begin
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            msize_q     <= '0;
            hcnt_q      <= 6'd0;
            rcnt_q      <= 6'd0;
            rvld_q      <= 1'b0;
            sig_ok_q    <= 1'b0;
            fsize_q     <= 32'd0;
            picw_q      <= 16'd0;
            pich_q      <= 16'd0;
            nfr_q       <= 32'd0;
            err_q       <= 2'd0;
            fidx_q      <= '0;
            fcnt_q      <= 32'd0;
            iss_left_q  <= 32'd0;
            emit_left_q <= 32'd0;
            first_q     <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            msize_q     <= msize_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            rvld_q      <= rd_en;
            sig_ok_q    <= sig_ok_d;
            fsize_q     <= fsize_d;
            picw_q      <= picw_d;
            pich_q      <= pich_d;
            nfr_q       <= nfr_d;
            err_q       <= err_d;
            fidx_q      <= fidx_d;
            fcnt_q      <= fcnt_d;
            iss_left_q  <= iss_left_d;
            emit_left_q <= emit_left_d;
            first_q     <= first_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Output buffer storage; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ivf_frame_streamer.sv
// Directed bench for ivf_frame_streamer: builds IVF images in a byte memory,
// runs them through the streamer and scores the emitted beats.
module tb_ivf_frame_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_size = 16'd0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_frame_idx;
    logic [31:0] frame_size;
    logic [15:0] pic_width;
    logic [15:0] pic_height;
    logic [31:0] num_frames;
    logic        busy;
    logic        done;
    logic [1:0]  error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  img [0:65535];
    int          wp;
    int          fi;
    logic [17:0] exp_q [$];   // {idx, sof, eof, data}
    logic [17:0] rx_q  [$];
    bit          seen_valid;

    always #5 clk = ~clk;

    // One-cycle-latency byte memory.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= img[mem_addr];
    end

    ivf_frame_streamer #(.ADDR_W(16), .MAX_FRAME_BYTES(65535), .FRAME_IDX_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_size(mem_size),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .out_frame_idx(out_frame_idx),
        .frame_size(frame_size), .pic_width(pic_width), .pic_height(pic_height),
        .num_frames(num_frames), .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic put_hdr(input int w, input int h, input int n);
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[0] = 8'h44; img[1] = 8'h4B; img[2] = 8'h49; img[3] = 8'h46;
        img[6] = 8'd32;
        img[8] = 8'h41; img[9] = 8'h56; img[10] = 8'h30; img[11] = 8'h32;
        img[12] = w[7:0];  img[13] = w[15:8];
        img[14] = h[7:0];  img[15] = h[15:8];
        img[16] = 8'd30;   img[20] = 8'd1;
        img[24] = n[7:0];  img[25] = n[15:8]; img[26] = n[23:16]; img[27] = n[31:24];
        wp = 32;
        fi = 0;
        exp_q.delete();
    endtask

    task automatic put_frame(input int size_field, input int len, input bit emit);
        logic [7:0] b;
        img[wp]   = size_field[7:0];
        img[wp+1] = size_field[15:8];
        img[wp+2] = size_field[23:16];
        img[wp+3] = size_field[31:24];
        for (int i = 4; i < 12; i++) img[wp+i] = 8'(8'hA0 + i);
        wp += 12;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            img[wp+i] = b;
            if (emit) exp_q.push_back({8'(fi), (i == 0), (i == len - 1), b});
        end
        wp += len;
        if (emit) fi++;
    endtask

    task automatic pulse_start(input int msz);
        @(negedge clk);
        mem_size = 16'(msz);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Clocks the run until busy drops, a byte count is reached, or the budget
    // expires, recording every accepted beat and checking stall stability.
    task automatic collect(input int max_cyc, input bit rnd, input int stop_at);
        bit          prev_stall = 1'b0;
        logic [17:0] held = '0;
        logic [17:0] cur;
        bit          ended = 1'b0;
        for (int c = 0; c < max_cyc && !ended; c++) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {out_frame_idx, out_sof, out_eof, out_data};
            if (out_valid) seen_valid = 1'b1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", cur, held);
            end
            if (mem_rd_en) chk("addr_range", (mem_addr < mem_size), 1);
            if (out_valid && out_ready) rx_q.push_back(cur);
            prev_stall = out_valid && !out_ready;
            held = cur;
            if (stop_at > 0 && rx_q.size() == stop_at) ended = 1'b1;
            else if (!busy) ended = 1'b1;
        end
        chk("run_timeout", ended, 1);
        out_ready = 1'b1;
    endtask

    task automatic compare_stream();
        chk("beat_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk("beat", rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_width", pic_width, 0);

        // 1: two-frame 64x64 container, consumer always ready.
        put_hdr(64, 64, 2);
        put_frame(3392, 3392, 1);
        put_frame(47, 47, 1);
        chk("img_size", wp, 3495);
        rx_q.delete();
        pulse_start(wp);
        collect(10000, 1'b0, 0);
        compare_stream();
        chk("t1_width", pic_width, 64);
        chk("t1_height", pic_height, 64);
        chk("t1_nframes", num_frames, 2);
        chk("t1_fsize", frame_size, 47);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_busy", busy, 0);

        // 2: same image, consumer ready about half the time.
        rx_q.delete();
        pulse_start(wp);
        collect(20000, 1'b1, 0);
        compare_stream();
        chk("t2_done", done, 1);
        chk("t2_error", error, 0);

        // 3: corrupt signature byte 0.
        img[0] = 8'h58;
        seen_valid = 1'b0;
        pulse_start(wp);
        n = 0;
        while (error == 2'd0 && n < 8) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
            n++;
        end
        chk("t3_error", error, 1);
        chk("t3_latency_ok", (n <= 6), 1);
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("t3_no_valid", seen_valid, 0);
        chk("t3_busy", busy, 0);
        chk("t3_done", done, 0);
        chk("t3_width_held", pic_width, 64);

        // 4: second frame claims 100 bytes but only 47 are present.
        put_hdr(32, 16, 2);
        put_frame(20, 20, 1);
        put_frame(100, 47, 0);
        rx_q.delete();
        pulse_start(wp);
        collect(2000, 1'b0, 0);
        compare_stream();
        chk("t4_error", error, 3);
        chk("t4_done", done, 0);
        chk("t4_fsize", frame_size, 100);
        chk("t4_width", pic_width, 32);
        chk("t4_valid", out_valid, 0);

        // 5: reset in the middle of frame 0, then replay from the start.
        put_hdr(64, 64, 2);
        put_frame(3392, 3392, 1);
        put_frame(47, 47, 1);
        rx_q.delete();
        pulse_start(wp);
        collect(5000, 1'b0, 1000);
        chk("t5_partial", rx_q.size(), 1000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_valid_after_rst", out_valid, 0);
        chk("t5_busy_after_rst", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("t5_quiet", seen_valid, 0);
        rx_q.delete();
        pulse_start(wp);
        collect(10000, 1'b0, 0);
        compare_stream();
        chk("t5_done", done, 1);

        // 6: one-byte frame, clean end at mem_size, start while busy ignored.
        put_hdr(16, 16, 0);
        put_frame(1, 1, 1);
        rx_q.delete();
        pulse_start(wp);
        repeat (8) @(negedge clk);
        chk("t6_busy", busy, 1);
        mem_size = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mem_size = 16'(wp);
        collect(500, 1'b0, 0);
        compare_stream();
        if (rx_q.size() > 0) chk("t6_sof_eof", rx_q[0][9:8], 2'b11);
        chk("t6_done", done, 1);
        chk("t6_error", error, 0);
        chk("t6_nframes", num_frames, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
